// File: rtl/mips_syscall_unit_pkg.sv
// Shared service codes and state encodings for the syscall unit, its core and benches.
package mips_syscall_unit_pkg;

    localparam int unsigned SYS_PRINT_INT  = 1;
    localparam int unsigned SYS_EXIT       = 10;
    localparam int unsigned SYS_PRINT_CHAR = 11;
    localparam int unsigned SYS_EXIT2      = 17;

    localparam int unsigned CHAR_W = 8;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

endpackage

// File: rtl/mips_syscall_unit_fifo.sv
// Synchronous FIFO buffering console records; pointers wrap naturally, count is one bit wider.
module syscall_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Guard against overflow/underflow even if the caller misbehaves.
    always_comb begin
        full    = (count == CW'(DEPTH));
        empty   = (count == '0);
        do_push = push && !full;
        do_pop  = pop && !empty;
        dout    = mem[rd_ptr];
    end

    // Storage array; contents need no reset since empty masks the head.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mips_syscall_unit.sv
// Syscall service stage: decodes $v0, queues print records, halts the core on exit.
module mips_syscall_unit
    import mips_syscall_unit_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              syscall_valid,
    input  logic [DATA_W-1:0] v0,
    input  logic [DATA_W-1:0] a0,
    output logic              stall,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_is_char,
    output logic              halted,
    output logic              drained,
    output logic [DATA_W-1:0] exit_code,
    output logic              bad_syscall
);

    localparam int unsigned FW = DATA_W + 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    state_t          state;
    logic            is_int;
    logic            is_char;
    logic            is_print;
    logic            is_exit;
    logic            is_exit2;
    logic            push;
    logic            pop;
    logic [FW-1:0]   push_rec;
    logic [FW-1:0]   head;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;

    // Service decode, back-pressure and head presentation.
    always_comb begin
        is_int   = (v0 == DATA_W'(SYS_PRINT_INT));
        is_char  = (v0 == DATA_W'(SYS_PRINT_CHAR));
        is_exit  = (v0 == DATA_W'(SYS_EXIT));
        is_exit2 = (v0 == DATA_W'(SYS_EXIT2));
        is_print = is_int || is_char;

        // Stall never depends on out_ready: a full FIFO blocks even if it pops this cycle.
        stall = (state == ST_HALTED) || (syscall_valid && is_print && fifo_full);
        push  = (state == ST_RUN) && syscall_valid && is_print && !fifo_full;
        pop   = out_ready && !fifo_empty;

        push_rec = {1'b0, a0};
        if (is_char) begin
            push_rec = {1'b1, (DATA_W - CHAR_W)'(0), a0[CHAR_W-1:0]};
        end

        out_valid   = (fifo_count != '0);
        out_data    = fifo_empty ? '0 : head[DATA_W-1:0];
        out_is_char = !fifo_empty && head[DATA_W];
        halted      = (state == ST_HALTED);
        drained     = halted && fifo_empty;
    end

    // RUN/HALTED state machine with sticky exit code and bad-code flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_RUN;
            exit_code   <= '0;
            bad_syscall <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (syscall_valid) begin
                        if (is_exit) begin
                            state     <= ST_HALTED;
                            exit_code <= '0;
                        end else if (is_exit2) begin
                            state     <= ST_HALTED;
                            exit_code <= a0;
                        end else if (!is_print) begin
                            bad_syscall <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_HALTED;
                end
            endcase
        end
    end

    syscall_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .din   (push_rec),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_mips_syscall_unit.sv
// Directed bench for mips_syscall_unit with hand-computed expectations.
module tb_mips_syscall_unit;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic              syscall_valid;
    logic [DATA_W-1:0] v0;
    logic [DATA_W-1:0] a0;
    logic              stall;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_is_char;
    logic              halted;
    logic              drained;
    logic [DATA_W-1:0] exit_code;
    logic              bad_syscall;

    int total = 0;
    int bad   = 0;

    mips_syscall_unit #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .syscall_valid (syscall_valid),
        .v0            (v0),
        .a0            (a0),
        .stall         (stall),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_is_char   (out_is_char),
        .halted        (halted),
        .drained       (drained),
        .exit_code     (exit_code),
        .bad_syscall   (bad_syscall)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        syscall_valid = 1'b0;
        v0            = '0;
        a0            = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic sys(input logic [31:0] code, input logic [31:0] arg);
        syscall_valid = 1'b1;
        v0            = code;
        a0            = arg;
        #1;
    endtask

    task automatic check_reset_state(input string pfx);
        chk({pfx, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({pfx, "_out_data"}, out_data, 32'd0);
        chk({pfx, "_out_is_char"}, 32'(out_is_char), 32'd0);
        chk({pfx, "_halted"}, 32'(halted), 32'd0);
        chk({pfx, "_drained"}, 32'(drained), 32'd0);
        chk({pfx, "_exit_code"}, exit_code, 32'd0);
        chk({pfx, "_bad"}, 32'(bad_syscall), 32'd0);
        chk({pfx, "_stall"}, 32'(stall), 32'd0);
    endtask

    initial begin
        out_ready = 1'b0;
        do_reset();
        check_reset_state("rst");

        // Print sequence with a ready consumer.
        out_ready = 1'b1;
        sys(32'd1, 32'd42);
        chk("pr_stall0", 32'(stall), 32'd0);
        tick();
        sys(32'd11, 32'h141);
        chk("pr_v0", 32'(out_valid), 32'd1);
        chk("pr_d0", out_data, 32'd42);
        chk("pr_c0", 32'(out_is_char), 32'd0);
        chk("pr_stall1", 32'(stall), 32'd0);
        tick();
        syscall_valid = 1'b0;
        #1;
        chk("pr_v1", 32'(out_valid), 32'd1);
        chk("pr_d1", out_data, 32'h41);
        chk("pr_c1", 32'(out_is_char), 32'd1);
        tick();
        chk("pr_empty", 32'(out_valid), 32'd0);

        // Unknown service code.
        sys(32'd99, 32'd5);
        chk("bad_stall", 32'(stall), 32'd0);
        tick();
        sys(32'd1, 32'd7);
        chk("bad_flag", 32'(bad_syscall), 32'd1);
        chk("bad_nopush", 32'(out_valid), 32'd0);
        tick();
        syscall_valid = 1'b0;
        #1;
        chk("bad_sticky", 32'(bad_syscall), 32'd1);
        chk("bad_print", out_data, 32'd7);
        tick();
        chk("bad_drain", 32'(out_valid), 32'd0);

        // Back-pressure with a stalled consumer.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sys(32'd1, 32'(i));
            chk("bp_fill_stall", 32'(stall), 32'd0);
            tick();
        end
        sys(32'd1, 32'd8);
        chk("bp_stall9", 32'(stall), 32'd1);
        tick();
        chk("bp_stall_hold", 32'(stall), 32'd1);
        chk("bp_head_hold", out_data, 32'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_stall_ready", 32'(stall), 32'd1);
        tick();
        out_ready = 1'b0;
        #1;
        chk("bp_after_pop_head", out_data, 32'd1);
        chk("bp_after_pop_stall", 32'(stall), 32'd0);
        tick();
        syscall_valid = 1'b0;
        out_ready     = 1'b1;
        #1;
        for (int i = 1; i <= 8; i++) begin
            chk("bp_order", out_data, 32'(i));
            tick();
        end
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Exit2 with two entries queued.
        do_reset();
        out_ready = 1'b0;
        sys(32'd1, 32'd5);
        tick();
        sys(32'd11, 32'h41);
        tick();
        sys(32'd17, 32'hFFFF_FFFD);
        chk("ex2_stall_exitcycle", 32'(stall), 32'd0);
        tick();
        sys(32'd1, 32'd77);
        chk("ex2_halted", 32'(halted), 32'd1);
        chk("ex2_code", exit_code, 32'hFFFF_FFFD);
        chk("ex2_stall", 32'(stall), 32'd1);
        chk("ex2_drained0", 32'(drained), 32'd0);
        tick();
        sys(32'd99, 32'd0);
        tick();
        syscall_valid = 1'b0;
        #1;
        chk("ex2_ignored_bad", 32'(bad_syscall), 32'd0);
        chk("ex2_head", out_data, 32'd5);
        out_ready = 1'b1;
        tick();
        chk("ex2_second", out_data, 32'h41);
        chk("ex2_second_char", 32'(out_is_char), 32'd1);
        chk("ex2_drained_wait", 32'(drained), 32'd0);
        tick();
        chk("ex2_empty", 32'(out_valid), 32'd0);
        chk("ex2_drained", 32'(drained), 32'd1);
        chk("ex2_stall_sticky", 32'(stall), 32'd1);

        // Plain exit.
        do_reset();
        sys(32'd10, 32'd123);
        tick();
        syscall_valid = 1'b0;
        #1;
        chk("ex_halted", 32'(halted), 32'd1);
        chk("ex_code", exit_code, 32'd0);
        chk("ex_nopush", 32'(out_valid), 32'd0);
        chk("ex_drained", 32'(drained), 32'd1);

        // Reset mid-run with queued output and halted state.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sys(32'd1, 32'(i + 10));
            tick();
        end
        sys(32'd17, 32'd9);
        tick();
        syscall_valid = 1'b0;
        #1;
        chk("mr_halted", 32'(halted), 32'd1);
        chk("mr_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check_reset_state("mr");
        out_ready = 1'b1;
        sys(32'd1, 32'd3);
        tick();
        syscall_valid = 1'b0;
        #1;
        chk("mr_run_print", out_data, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
